// File: rtl/vend_coin_sched.sv
// Coin scheduler: arbitrates two coin acceptors, issues one 5/10 pulse per coin,
// then watches for product/change strobes and runs the motor/hopper on a vend.
module vend_coin_sched #(
    parameter int unsigned GAP       = 3,
    parameter int unsigned MOTOR_CYC = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_valid,
    input  logic       a_coin,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic       b_coin,
    output logic       b_ready,
    output logic       c5,
    output logic       c10,
    input  logic       p_out,
    input  logic       c_out,
    output logic       motor_en,
    output logic       change_en,
    output logic       busy,
    output logic [7:0] coin_cnt,
    output logic [7:0] vend_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_DISPENSE} state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       vend_f, vend_f_nxt;
    logic       chg_f, chg_f_nxt;
    logic       coin_type, coin_type_nxt;
    logic       last_b;
    logic       accept;
    logic       vend_done;

    // Grants are gated by rst so both readies read 0 for the whole reset.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (state == S_IDLE && rst) begin
            a_ready = a_valid && (!b_valid || last_b);
            b_ready = b_valid && (!a_valid || !last_b);
        end
    end

    assign accept = a_ready || b_ready;
    assign busy   = (state != S_IDLE);

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        vend_f_nxt    = vend_f;
        chg_f_nxt     = chg_f;
        coin_type_nxt = coin_type;
        vend_done     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt     = S_ISSUE;
                    coin_type_nxt = a_ready ? a_coin : b_coin;
                end
            end
            S_ISSUE: begin
                vend_f_nxt = vend_f | p_out;
                chg_f_nxt  = chg_f | c_out;
                state_nxt  = S_GAP;
                cnt_nxt    = 8'(GAP - 1);
            end
            S_GAP: begin
                vend_f_nxt = vend_f | p_out;
                chg_f_nxt  = chg_f | c_out;
                // Strobes on the final GAP cycle still count toward the decision.
                if (cnt == 8'd0) begin
                    if (vend_f_nxt) begin
                        state_nxt = S_DISPENSE;
                        cnt_nxt   = 8'(MOTOR_CYC - 1);
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            S_DISPENSE: begin
                if (cnt == 8'd0) begin
                    state_nxt  = S_IDLE;
                    vend_done  = 1'b1;
                    vend_f_nxt = 1'b0;
                    chg_f_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            vend_f    <= 1'b0;
            chg_f     <= 1'b0;
            coin_type <= 1'b0;
            last_b    <= 1'b1;
            coin_cnt  <= '0;
            vend_cnt  <= '0;
            c5        <= 1'b0;
            c10       <= 1'b0;
            motor_en  <= 1'b0;
            change_en <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            vend_f    <= vend_f_nxt;
            chg_f     <= chg_f_nxt;
            coin_type <= coin_type_nxt;
            if (accept) begin
                last_b <= b_ready;
            end
            if (accept && coin_cnt != 8'hFF) begin
                coin_cnt <= coin_cnt + 8'd1;
            end
            if (vend_done && vend_cnt != 8'hFF) begin
                vend_cnt <= vend_cnt + 8'd1;
            end
            // Drive outputs from the next state so they are flops aligned to it.
            c5        <= (state_nxt == S_ISSUE) && !coin_type_nxt;
            c10       <= (state_nxt == S_ISSUE) && coin_type_nxt;
            motor_en  <= (state_nxt == S_DISPENSE);
            change_en <= (state_nxt == S_DISPENSE) && chg_f_nxt;
        end
    end

endmodule
